dmem_arbiter: RTL and testbench

- Shares the single-port 32-word data memory between two requesters: the core MEM stage (port core_) and a debug/loader port (port dbg_).
- Each requester uses a valid/ready request channel and a response channel.
- The block sits between the MEM stage and the data memory. It drives the memory's mem_write/mem_read/address/write_data and returns the memory's registered result to whichever requester issued the read.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arb_grant.sv | 50 +++++
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: requester IDs, the
// pending-response entry and the default word-index width.
package dmem_arb_pkg;

  // Default word-index width; the memory holds 2**ADDR_W words.
  localparam int ADDR_W_DEFAULT = 5;

  // Requester identifiers, also used as the round-robin pointer encoding.
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  // Bookkeeping for the one request in flight between issue and response.
  typedef struct packed {
    logic valid;
    logic id;
    logic is_read;
    logic err;
  } pend_t;

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational grant logic for the data-memory arbiter.
// Produces a one-hot grant (bit 0 = core, bit 1 = dbg).
// Build option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// steered by ptr; without it, the core always beats dbg and ptr is ignored.
module dmem_arb_grant
  import dmem_arb_pkg::*;
(
  input  logic       core_valid,
  input  logic       dbg_valid,
  input  logic       ptr,
  output logic [1:0] grant
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Contention goes to the favoured requester; a lone requester always wins.
  always_comb begin
    grant = 2'b00;
    if (core_valid && dbg_valid) begin
      if (ptr == REQ_DBG) begin
        grant = 2'b10;
      end else begin
        grant = 2'b01;
      end
    end else if (core_valid) begin
      grant = 2'b01;
    end else if (dbg_valid) begin
      grant = 2'b10;
    end else begin
      grant = 2'b00;
    end
  end
`else
  // The pointer has no meaning under fixed priority.
  logic unused_ptr_s;
  assign unused_ptr_s = ptr;

  // Fixed priority: the core pipeline is never stalled by the debug port.
  always_comb begin
    grant = 2'b00;
    if (core_valid) begin
      grant = 2'b01;
    end else if (dbg_valid) begin
      grant = 2'b10;
    end else begin
      grant = 2'b00;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the core MEM stage
// and the debug/loader port. One request is issued per cycle; its response
// appears exactly one cycle later on the requester that issued it.
// Build option: DMEM_ARB_ROUND_ROBIN_EN enables round-robin arbitration
// (otherwise fixed priority, core first, and no pointer register exists).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_req_valid,
  input  logic        core_req_we,
  input  logic [31:0] core_req_addr,
  input  logic [31:0] core_req_wdata,
  output logic        core_req_ready,
  output logic        core_rsp_valid,
  output logic [31:0] core_rsp_rdata,
  output logic        core_rsp_err,
  input  logic        dbg_req_valid,
  input  logic        dbg_req_we,
  input  logic [31:0] dbg_req_addr,
  input  logic [31:0] dbg_req_wdata,
  output logic        dbg_req_ready,
  output logic        dbg_rsp_valid,
  output logic [31:0] dbg_rsp_rdata,
  output logic        dbg_rsp_err,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_result
);

  logic [1:0]  grant_s;
  logic        ptr_s;
  logic        core_valid_s;
  logic        dbg_valid_s;
  logic        win_we_s;
  logic [31:0] win_addr_s;
  logic [31:0] win_wdata_s;
  logic        accept_s;
  logic        err_s;
  pend_t       pend_r;

  // Nothing is granted while reset is held, so every output reads 0.
  assign core_valid_s = core_req_valid & ~reset;
  assign dbg_valid_s  = dbg_req_valid & ~reset;

  dmem_arb_grant u_grant (
    .core_valid (core_valid_s),
    .dbg_valid  (dbg_valid_s),
    .ptr        (ptr_s),
    .grant      (grant_s)
  );

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic ptr_r;

  // Hand priority to the other side whenever the favoured side is served.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_r <= REQ_CORE;
    end else if (grant_s[ptr_r]) begin
      ptr_r <= ~ptr_r;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr_s = ptr_r;
`else
  assign ptr_s = REQ_CORE;
`endif

  assign core_req_ready = grant_s[0];
  assign dbg_req_ready  = grant_s[1];
  assign accept_s       = |grant_s;

  // Route the granted requester's fields onto the shared issue path.
  always_comb begin
    win_we_s    = 1'b0;
    win_addr_s  = 32'd0;
    win_wdata_s = 32'd0;
    if (grant_s[1]) begin
      win_we_s    = dbg_req_we;
      win_addr_s  = dbg_req_addr;
      win_wdata_s = dbg_req_wdata;
    end else if (grant_s[0]) begin
      win_we_s    = core_req_we;
      win_addr_s  = core_req_addr;
      win_wdata_s = core_req_wdata;
    end else begin
      win_we_s    = 1'b0;
    end
  end

  // Misaligned or beyond the last word: accepted, answered, never issued.
  assign err_s = accept_s &&
                 ((win_addr_s[1:0] != 2'b00) ||
                  (win_addr_s[31:ADDR_W+2] != {(30-ADDR_W){1'b0}}));

  // Drive the memory only for a clean accepted request; idle otherwise.
  always_comb begin
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    mem_address    = 32'd0;
    mem_write_data = 32'd0;
    if (accept_s && !err_s) begin
      mem_address = {{(32-ADDR_W){1'b0}}, win_addr_s[ADDR_W+1:2]};
      if (win_we_s) begin
        mem_write      = 1'b1;
        mem_write_data = win_wdata_s;
      end else begin
        mem_read = 1'b1;
      end
    end else begin
      mem_write = 1'b0;
    end
  end

  // Remember who was served so the next cycle can route the response.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_r <= '0;
    end else begin
      pend_r.valid   <= accept_s;
      pend_r.id      <= grant_s[1];
      pend_r.is_read <= accept_s & ~win_we_s;
      pend_r.err     <= err_s;
    end
  end

  // Return the memory's registered result to the requester that asked.
  always_comb begin
    core_rsp_valid = 1'b0;
    core_rsp_rdata = 32'd0;
    core_rsp_err   = 1'b0;
    dbg_rsp_valid  = 1'b0;
    dbg_rsp_rdata  = 32'd0;
    dbg_rsp_err    = 1'b0;
    if (!reset && pend_r.valid) begin
      if (pend_r.id == REQ_DBG) begin
        dbg_rsp_valid = 1'b1;
        dbg_rsp_err   = pend_r.err;
        if (pend_r.is_read && !pend_r.err) begin
          dbg_rsp_rdata = mem_result;
        end else begin
          dbg_rsp_rdata = 32'd0;
        end
      end else begin
        core_rsp_valid = 1'b1;
        core_rsp_err   = pend_r.err;
        if (pend_r.is_read && !pend_r.err) begin
          core_rsp_rdata = mem_result;
        end else begin
          core_rsp_rdata = 32'd0;
        end
      end
    end else begin
      core_rsp_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized traffic, checked by a queue-based scoreboard against a
// behavioural model of the arbitration and memory contents.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int MEM_WORDS = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        core_req_valid, core_req_we, core_req_ready;
  logic [31:0] core_req_addr, core_req_wdata;
  logic        core_rsp_valid, core_rsp_err;
  logic [31:0] core_rsp_rdata;
  logic        dbg_req_valid, dbg_req_we, dbg_req_ready;
  logic [31:0] dbg_req_addr, dbg_req_wdata;
  logic        dbg_rsp_valid, dbg_rsp_err;
  logic [31:0] dbg_rsp_rdata;
  logic        mem_write, mem_read;
  logic [31:0] mem_address, mem_write_data, mem_result;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct {
    bit          port;   // 0 core, 1 dbg
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  logic [31:0] ref_mem [MEM_WORDS];
  bit          favour;          // requester preferred under contention
  bit          won_core, won_dbg;

  dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_we(core_req_we),
    .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
    .core_req_ready(core_req_ready), .core_rsp_valid(core_rsp_valid),
    .core_rsp_rdata(core_rsp_rdata), .core_rsp_err(core_rsp_err),
    .dbg_req_valid(dbg_req_valid), .dbg_req_we(dbg_req_we),
    .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
    .dbg_req_ready(dbg_req_ready), .dbg_rsp_valid(dbg_rsp_valid),
    .dbg_rsp_rdata(dbg_rsp_rdata), .dbg_rsp_err(dbg_rsp_err),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_result(mem_result)
  );

  always #5 clock = ~clock;

  // Cycle counter used to measure response latency
  always @(posedge clock) cyc <= cyc + 1;

  // Data memory stub: registered read; garbage on idle cycles; reset loads word i = i
  logic [31:0] stub_mem [MEM_WORDS];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) stub_mem[i] <= i;
      mem_result <= 32'd0;
    end else begin
      if (mem_write) stub_mem[mem_address[4:0]] <= mem_write_data;
      if (mem_read) mem_result <= stub_mem[mem_address[4:0]];
      else          mem_result <= $urandom;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = i;
    favour = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_core_ready"}, core_req_ready, 0);
    chk({tag, "_core_rsp_valid"}, core_rsp_valid, 0);
    chk({tag, "_core_rsp_rdata"}, core_rsp_rdata, 0);
    chk({tag, "_core_rsp_err"}, core_rsp_err, 0);
    chk({tag, "_dbg_ready"}, dbg_req_ready, 0);
    chk({tag, "_dbg_rsp_valid"}, dbg_rsp_valid, 0);
    chk({tag, "_dbg_rsp_rdata"}, dbg_rsp_rdata, 0);
    chk({tag, "_dbg_rsp_err"}, dbg_rsp_err, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_mem_read"}, mem_read, 0);
    chk({tag, "_mem_address"}, mem_address, 0);
    chk({tag, "_mem_write_data"}, mem_write_data, 0);
  endtask

  // Decide the winner from the arbitration rules, check the issue side, queue the response
  task automatic model_issue();
    bit          any, win, we, err;
    logic [31:0] addr, wdata;
    int          word;
    any = core_req_valid || dbg_req_valid;
    if (core_req_valid && dbg_req_valid) win = RR ? favour : 1'b0;
    else                                 win = !core_req_valid;
    won_core = any && !win;
    won_dbg  = any && win;
    chk("core_req_ready", core_req_ready, won_core);
    chk("dbg_req_ready", dbg_req_ready, won_dbg);
    if (!any) begin
      chk("idle_mem_read", mem_read, 0);
      chk("idle_mem_write", mem_write, 0);
      chk("idle_mem_address", mem_address, 0);
      chk("idle_mem_write_data", mem_write_data, 0);
      return;
    end
    addr  = win ? dbg_req_addr  : core_req_addr;
    wdata = win ? dbg_req_wdata : core_req_wdata;
    we    = win ? dbg_req_we    : core_req_we;
    err   = (addr % 4 != 0) || (addr >= MEM_WORDS * 4);
    word  = addr / 4;
    chk("mem_read", mem_read, !err && !we);
    chk("mem_write", mem_write, !err && we);
    chk("mem_address", mem_address, err ? 32'd0 : word);
    chk("mem_write_data", mem_write_data, (!err && we) ? wdata : 32'd0);
    exp_q.push_back('{port: win, rdata: (!err && !we) ? ref_mem[word] : 32'd0,
                      err: err, cyc: cyc});
    if (!err && we) ref_mem[word] = wdata;
    if (RR && win == favour) favour = ~favour;
  endtask

  // Apply one cycle of requests, check at the falling edge, advance past the rising edge
  task automatic drive(input bit cv, input bit cwe, input logic [31:0] ca, input logic [31:0] cd,
                       input bit dv, input bit dwe, input logic [31:0] da, input logic [31:0] dd);
    core_req_valid = cv; core_req_we = cwe; core_req_addr = ca; core_req_wdata = cd;
    dbg_req_valid  = dv; dbg_req_we  = dwe; dbg_req_addr  = da; dbg_req_wdata  = dd;
    @(negedge clock);
    model_issue();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0:       a = $urandom;                                  // usually out of range
      1:       a = ($urandom_range(0, 31) * 4) + $urandom_range(1, 3); // misaligned
      default: a = $urandom_range(0, 31) * 4;
    endcase
    return a;
  endfunction

  // Scoreboard monitor: pops and compares whenever a response is presented
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (core_rsp_valid && dbg_rsp_valid) begin
        tests_run++; tests_failed++;
        $display("FAIL rsp_both_ports: both rsp_valid set, expected one (cycle %0d)", cyc);
      end
      if (core_rsp_valid || dbg_rsp_valid) begin
        if (exp_q.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL rsp_unexpected: got a response, expected none (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_port", dbg_rsp_valid, e.port);
          chk("rsp_rdata", e.port ? dbg_rsp_rdata : core_rsp_rdata, e.rdata);
          chk("rsp_err", e.port ? dbg_rsp_err : core_rsp_err, e.err);
          chk("rsp_latency", cyc - e.cyc, 1);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        tests_run++; tests_failed++;
        $display("FAIL rsp_missing: got no response, expected one from cycle %0d (cycle %0d)",
                 e.cyc, cyc);
      end
      if (!core_rsp_valid) begin
        chk("core_rsp_idle_rdata", core_rsp_rdata, 0);
        chk("core_rsp_idle_err", core_rsp_err, 0);
      end
      if (!dbg_rsp_valid) begin
        chk("dbg_rsp_idle_rdata", dbg_rsp_rdata, 0);
        chk("dbg_rsp_idle_err", dbg_rsp_err, 0);
      end
    end
  end

  initial begin
    bit          cp, dp, cwe, dwe;
    logic [31:0] ca, cd, da, dd;

    // Reset with a request present: nothing may be granted or issued
    reset = 1'b1;
    core_req_valid = 1'b1; core_req_we = 1'b0; core_req_addr = 32'h0; core_req_wdata = 32'h0;
    dbg_req_valid  = 1'b1; dbg_req_we  = 1'b1; dbg_req_addr  = 32'h4; dbg_req_wdata  = 32'h1;
    model_reset();
    @(posedge clock); @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    // Core load at 0x14 reads word 5
    drive(1, 0, 32'h14, 0, 0, 0, 0, 0);
    // Debug store then core load of the same word
    drive(0, 0, 0, 0, 1, 1, 32'h08, 32'hDEADBEEF);
    drive(1, 0, 32'h08, 0, 0, 0, 0, 0);
    // Contention for 4 cycles, loser holds its request; then let dbg drain
    for (int i = 0; i < 4; i++) drive(1, 0, 32'h00, 0, 1, 0, 32'h04, 0);
    drive(0, 0, 0, 0, 1, 0, 32'h04, 0);
    idle(1);
    // Error cases: misaligned and beyond the last word
    drive(1, 0, 32'h06, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h80, 0, 0, 0, 0, 0);
    drive(1, 1, 32'h80, 32'h1234, 0, 0, 0, 0);
    // Back-to-back loads
    drive(1, 0, 32'h00, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h04, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h0C, 0, 0, 0, 0, 0);
    idle(1);

    // Reset the cycle after a load is accepted: the response is dropped
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    check_all_zero("midreset");
    @(posedge clock); #1;
    reset = 1'b0;
    core_req_valid = 1'b0; dbg_req_valid = 1'b0;
    @(negedge clock);
    chk("post_reset_core_rsp_valid", core_rsp_valid, 0);
    chk("post_reset_dbg_rsp_valid", dbg_rsp_valid, 0);
    @(posedge clock); #1;

    // Randomized traffic; a requester that lost keeps its request unchanged
    cp = 0; dp = 0;
    cwe = 0; dwe = 0; ca = 0; cd = 0; da = 0; dd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!cp && $urandom_range(0, 3) != 0) begin
        cp = 1; cwe = $urandom_range(0, 1); ca = rand_addr(); cd = $urandom;
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1; dwe = $urandom_range(0, 1); da = rand_addr(); dd = $urandom;
      end
      drive(cp, cwe, ca, cd, dp, dwe, da, dd);
      if (won_core) cp = 0;
      if (won_dbg)  dp = 0;
    end
    idle(3);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
